// File: rtl/usbf_csr_arb_pkg.sv
// Shared types and constants for the CSR arbiter/sequencer.
//   state_e    : 2-bit FSM encoding (IDLE/ISSUE/WAIT/RESP)
//   csr_req_t  : latched access (write flag, byte address, write data)
//   in_window  : address-window decode on addr[31:12]
package usbf_csr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [19:0] CSR_BASE_31_12 = 20'h10042;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } csr_req_t;

    function automatic logic in_window(input logic [31:0] addr, input logic [19:0] base);
        return addr[31:12] == base;
    endfunction

endpackage

// File: rtl/usbf_csr_arb_rr_arb2.sv
// Two-way round-robin grant.
//   req_i    : request vector {m1, m0}
//   upd_i    : an access completed this cycle (response handshake)
//   upd_id_i : master that completed; the pointer moves to the other one
//   gnt_o    : one-hot grant (combinational), zero when nobody requests
module usbf_csr_arb_rr_arb2 (
    input  logic       hclk_i,
    input  logic       hrstn_i,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_id_i,
    output logic [1:0] gnt_o
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) ptr_d = ~upd_id_i;
    end

    always_ff @(posedge hclk_i or negedge hrstn_i) begin
        if (!hrstn_i) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end

    // The pointer only matters under contention; a lone requester always wins.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/usbf_csr_arb.sv
// Two-master arbiter/sequencer in front of the shared CSR port (hclk domain).
//   m0_* / m1_*         : request (valid/ready) and response (valid/ready) channels
//   wt_en_o / rd_en_o   : one-cycle CSR strobes; enable_o spans strobe + wait
//   addr_o / wdata_o    : latched access, stable through the CSR access
//   rdata_i             : captured on rd_ready_i
//   wt_ready_i/rd_ready_i : completion pulses from the PHY domain
// One access in flight; a timeout turns a lost completion into an error response.
module usbf_csr_arb
    import usbf_csr_arb_pkg::*;
#(
    parameter logic [19:0]     BASE_31_12 = CSR_BASE_31_12,
    parameter int unsigned     TO_W       = 8,
    parameter logic [TO_W-1:0] TO_MAX     = 8'd200
) (
    input  logic        hclk_i,
    input  logic        hrstn_i,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    input  logic        m0_req_write_i,
    input  logic [31:0] m0_req_addr_i,
    input  logic [31:0] m0_req_wdata_i,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    output logic [31:0] m0_rsp_rdata_o,
    output logic        m0_rsp_err_o,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    input  logic        m1_req_write_i,
    input  logic [31:0] m1_req_addr_i,
    input  logic [31:0] m1_req_wdata_i,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] m1_rsp_rdata_o,
    output logic        m1_rsp_err_o,
    output logic        wt_en_o,
    output logic        rd_en_o,
    output logic        enable_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i,
    input  logic        wt_ready_i,
    input  logic        rd_ready_i
);

    state_e          state_q, state_d;
    logic            mid_q, mid_d;
    csr_req_t        req_q, req_d, sel_req;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [1:0] gnt;
    logic       acc, in_win, pulse, timeout, rsp_hs;

    usbf_csr_arb_rr_arb2 u_rr (
        .hclk_i   (hclk_i),
        .hrstn_i  (hrstn_i),
        .req_i    ({m1_req_valid_i, m0_req_valid_i}),
        .upd_i    (rsp_hs),
        .upd_id_i (mid_q),
        .gnt_o    (gnt)
    );

    always_comb begin
        sel_req.write = gnt[1] ? m1_req_write_i : m0_req_write_i;
        sel_req.addr  = gnt[1] ? m1_req_addr_i  : m0_req_addr_i;
        sel_req.wdata = gnt[1] ? m1_req_wdata_i : m0_req_wdata_i;
    end

    assign acc     = (state_q == ST_IDLE) && (gnt != 2'b00);
    assign in_win  = in_window(sel_req.addr, BASE_31_12);
    // Only the completion matching the access kind counts, and only in WAIT,
    // so a pulse coincident with the strobe or a late ack is dropped.
    assign pulse   = (state_q == ST_WAIT) && (req_q.write ? wt_ready_i : rd_ready_i);
    assign timeout = (state_q == ST_WAIT) && (cnt_q == TO_MAX - 1'b1);
    assign rsp_hs  = (state_q == ST_RESP) && (mid_q ? m1_rsp_ready_i : m0_rsp_ready_i);

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (acc) state_d = in_win ? ST_ISSUE : ST_RESP;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (pulse || timeout) state_d = ST_RESP;
            ST_RESP:  if (rsp_hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath
    always_comb begin
        mid_d   = mid_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (acc) begin
                mid_d   = gnt[1];
                err_d   = ~in_win;
                rdata_d = '0;
                // Rejected requests never reach the bus, so addr_o/wdata_o
                // keep showing the last real access.
                if (in_win) req_d = sel_req;
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (pulse) begin
                    err_d   = 1'b0;
                    rdata_d = req_q.write ? 32'd0 : rdata_i;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk_i or negedge hrstn_i) begin
        if (!hrstn_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge hclk_i or negedge hrstn_i) begin
        if (!hrstn_i) begin
            mid_q   <= 1'b0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            mid_q   <= mid_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs
    always_comb begin
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        wt_en_o        = 1'b0;
        rd_en_o        = 1'b0;
        enable_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                m0_req_ready_o = gnt[0];
                m1_req_ready_o = gnt[1];
            end
            ST_ISSUE: begin
                wt_en_o  = req_q.write;
                rd_en_o  = ~req_q.write;
                enable_o = 1'b1;
            end
            ST_WAIT: enable_o = 1'b1;
            ST_RESP: begin
                m0_rsp_valid_o = ~mid_q;
                m1_rsp_valid_o = mid_q;
            end
            default: ;
        endcase
    end

    assign m0_rsp_rdata_o = m0_rsp_valid_o ? rdata_q : 32'd0;
    assign m1_rsp_rdata_o = m1_rsp_valid_o ? rdata_q : 32'd0;
    assign m0_rsp_err_o   = m0_rsp_valid_o & err_q;
    assign m1_rsp_err_o   = m1_rsp_valid_o & err_q;
    assign addr_o         = req_q.addr;
    assign wdata_o        = req_q.wdata;

endmodule

// File: tb/tb_usbf_csr_arb.sv
// Randomized bench with a transaction-level reference model and scoreboard.
// The CSR responder derives its behaviour from the access address:
//   addr[11:8] == F : never completes (timeout, then a late ack in RESP)
//   addr[11:8] == E : completes on the very last WAIT cycle
//   otherwise       : completes addr[5:2]+1 cycles after the strobe
// Read data returned by the CSR is a fixed function of the address.
module tb_usbf_csr_arb;

    localparam logic [19:0] BASE   = 20'h10042;
    localparam int          TO_MAX = 200;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
        int          nstb;
    } exp_t;

    logic hclk_i = 1'b0;
    logic hrstn_i;
    logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
    logic wt_en_o, rd_en_o, enable_o, wt_ready_i, rd_ready_i;
    logic [31:0] addr_o, wdata_o, rdata_i;

    usbf_csr_arb dut (
        .hclk_i(hclk_i), .hrstn_i(hrstn_i),
        .m0_req_valid_i(req_valid[0]), .m0_req_ready_o(req_ready[0]),
        .m0_req_write_i(req_write[0]), .m0_req_addr_i(req_addr[0]),
        .m0_req_wdata_i(req_wdata[0]), .m0_rsp_valid_o(rsp_valid[0]),
        .m0_rsp_ready_i(rsp_ready[0]), .m0_rsp_rdata_o(rsp_rdata[0]),
        .m0_rsp_err_o(rsp_err[0]),
        .m1_req_valid_i(req_valid[1]), .m1_req_ready_o(req_ready[1]),
        .m1_req_write_i(req_write[1]), .m1_req_addr_i(req_addr[1]),
        .m1_req_wdata_i(req_wdata[1]), .m1_rsp_valid_o(rsp_valid[1]),
        .m1_rsp_ready_i(rsp_ready[1]), .m1_rsp_rdata_o(rsp_rdata[1]),
        .m1_rsp_err_o(rsp_err[1]),
        .wt_en_o(wt_en_o), .rd_en_o(rd_en_o), .enable_o(enable_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i),
        .wt_ready_i(wt_ready_i), .rd_ready_i(rd_ready_i)
    );

    always #5 hclk_i = ~hclk_i;

    int cyc = 0;
    always @(posedge hclk_i) cyc <= cyc + 1;

    int   vecs = 0, errs = 0;
    exp_t q0[$], q1[$];
    req_t dq0[$], dq1[$];
    bit   busy = 0, ptr_exp = 0;
    int   acc_cyc = 0, strobes = 0;
    req_t infl;
    logic [1:0] vld_prev = '0;

    function automatic int delay_of(input logic [31:0] a);
        if (a[11:8] == 4'hF) return -1;
        if (a[11:8] == 4'hE) return TO_MAX;
        return int'(a[5:2]) + 1;
    endfunction

    function automatic logic [31:0] csr_val(input logic [31:0] a);
        return a ^ 32'h3C5A_96E1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ctrl", 64'({wt_en_o, rd_en_o, enable_o, req_ready, rsp_valid, rsp_err}), 64'd0);
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_wdata", 64'(wdata_o), 64'd0);
        chk("rst_rdata", {rsp_rdata[1], rsp_rdata[0]}, 64'd0);
    endtask

    // CSR responder
    bit          pend = 0, s_wr;
    int          s_cyc, ack_at;
    logic [31:0] s_addr;
    initial begin
        wt_ready_i = 0; rd_ready_i = 0; rdata_i = 0;
        forever begin
            @(negedge hclk_i); #1;
            wt_ready_i = 0; rd_ready_i = 0; rdata_i = $urandom;
            if (!hrstn_i) pend = 0;
            else if (pend) begin
                if (cyc - s_cyc == ack_at) begin
                    if (s_wr) wt_ready_i = 1;
                    else begin rd_ready_i = 1; rdata_i = csr_val(s_addr); end
                    pend = 0;
                end else if ($urandom_range(0, 3) == 0) begin
                    if (s_wr) rd_ready_i = 1; else wt_ready_i = 1;
                end
            end else if (wt_en_o || rd_en_o) begin
                int d;
                s_cyc = cyc; s_wr = wt_en_o; s_addr = addr_o;
                d = delay_of(addr_o);
                ack_at = (d < 0) ? TO_MAX + 1 : d;
                pend = 1;
                // A matching pulse in the strobe cycle must not complete the access.
                if ($urandom_range(0, 1) == 0) begin
                    if (s_wr) wt_ready_i = 1; else rd_ready_i = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge hclk_i);
        rsp_ready = 2'($urandom);
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge hclk_i); #3;
        if (hrstn_i) begin
            if (req_ready != 2'b00) begin
                logic kb;
                req_t r;
                exp_t e;
                int   d;
                kb = req_ready[1];
                r.w = req_write[kb]; r.a = req_addr[kb]; r.d = req_wdata[kb];
                chk("grant_onehot", 64'($countones(req_ready)), 64'd1);
                chk("grant_valid", 64'(req_valid[kb]), 64'd1);
                chk("single_outstanding", 64'(busy), 64'd0);
                if (req_valid == 2'b11) chk("rr_grant", 64'(kb), 64'(ptr_exp));
                d = delay_of(r.a);
                if (r.a[31:12] != BASE) begin
                    e.err = 1; e.rdata = 0; e.due = cyc + 1; e.nstb = 0;
                end else if (d < 0) begin
                    e.err = 1; e.rdata = 0; e.due = cyc + 2 + TO_MAX; e.nstb = 1;
                end else begin
                    e.err = 0; e.rdata = r.w ? 32'd0 : csr_val(r.a);
                    e.due = cyc + 2 + d; e.nstb = 1;
                end
                if (kb) q1.push_back(e); else q0.push_back(e);
                busy = 1; acc_cyc = cyc; strobes = 0; infl = r;
            end
            if (wt_en_o || rd_en_o) begin
                strobes++;
                chk("strobe_cycle", 64'(cyc), 64'(acc_cyc + 1));
                chk("strobe_kind", 64'({wt_en_o, rd_en_o}), infl.w ? 64'd2 : 64'd1);
                chk("strobe_addr", 64'(addr_o), 64'(infl.a));
                if (infl.w) chk("strobe_wdata", 64'(wdata_o), 64'(infl.d));
                chk("strobe_enable", 64'(enable_o), 64'd1);
            end
            if (rsp_valid == 2'b11) chk("rsp_both_valid", 64'(rsp_valid), 64'd1);
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = (k == 0) ? q0[0] : q1[0];
                        if (!vld_prev[k]) begin
                            chk("rsp_cycle", 64'(cyc), 64'(e.due));
                            chk("rsp_enable_low", 64'(enable_o), 64'd0);
                        end
                        if (rsp_ready[k]) begin
                            chk("rsp_err", 64'(rsp_err[k]), 64'(e.err));
                            chk("rsp_rdata", 64'(rsp_rdata[k]), 64'(e.rdata));
                            chk("strobe_count", 64'(strobes), 64'(e.nstb));
                            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                            busy = 0;
                            ptr_exp = (k == 0);
                        end
                    end
                end
            end
            vld_prev = rsp_valid;
        end
    end

    task automatic run_master(input int k, input int n);
        @(negedge hclk_i);
        for (int i = 0; i < n; i++) begin
            req_t r;
            int   idle;
            bit   got;
            if (k == 0 && dq0.size() != 0) begin r = dq0.pop_front(); idle = 0; end
            else if (k == 1 && dq1.size() != 0) begin r = dq1.pop_front(); idle = 0; end
            else begin
                int c;
                r.w = 1'($urandom); r.d = $urandom; idle = $urandom_range(0, 3);
                if ($urandom_range(0, 99) < 85) begin
                    c = $urandom_range(0, 19);
                    r.a = {BASE, (c == 0) ? 4'hF : (c == 1) ? 4'hE : 4'($urandom_range(0, 13)), 8'($urandom)};
                end else begin
                    r.a = $urandom;
                    if (r.a[31:12] == BASE) r.a[31] = ~r.a[31];
                end
            end
            req_valid[k] = 1; req_write[k] = r.w; req_addr[k] = r.a; req_wdata[k] = r.d;
            got = 0;
            for (int c = 0; c < 2000 && !got; c++) begin
                #3;
                if (req_ready[k]) got = 1;
                @(negedge hclk_i);
            end
            req_valid[k] = 0;
            if (!got) begin
                vecs++; errs++;
                $display("FAIL accept_timeout: master %0d never accepted", k);
                return;
            end
            repeat (idle) @(negedge hclk_i);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && (busy || q0.size() != 0 || q1.size() != 0); c++)
            @(negedge hclk_i);
        if (busy || q0.size() != 0 || q1.size() != 0) begin
            vecs++; errs++;
            $display("FAIL drain_timeout: outstanding responses %0d/%0d", q0.size(), q1.size());
        end
    endtask

    initial begin
        hrstn_i = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge hclk_i);
        chk_reset_outputs();
        hrstn_i = 1;

        dq0.push_back('{w: 1'b0, a: 32'h1004_2004, d: 32'h0});
        dq0.push_back('{w: 1'b1, a: 32'h1004_2010, d: 32'hA5A5_0001});
        dq0.push_back('{w: 1'b0, a: 32'h1004_2F08, d: 32'h0});
        dq0.push_back('{w: 1'b0, a: 32'h1004_2000, d: 32'h0});
        dq1.push_back('{w: 1'b0, a: 32'h1004_2008, d: 32'h0});
        dq1.push_back('{w: 1'b0, a: 32'h2000_0000, d: 32'h0});
        dq1.push_back('{w: 1'b0, a: 32'h1004_2E00, d: 32'h0});
        dq1.push_back('{w: 1'b0, a: 32'h1004_200C, d: 32'h0});
        fork
            run_master(0, 30);
            run_master(1, 30);
        join
        drain();

        // Reset in the middle of a WAIT that would otherwise time out.
        dq0.push_back('{w: 1'b0, a: 32'h1004_2F10, d: 32'h0});
        run_master(0, 1);
        repeat (10) @(negedge hclk_i);
        #5 hrstn_i = 0;
        #1 chk_reset_outputs();
        q0.delete(); q1.delete();
        busy = 0; ptr_exp = 0; vld_prev = '0;
        repeat (3) @(negedge hclk_i);
        #5 hrstn_i = 1;

        fork
            run_master(0, 6);
            run_master(1, 6);
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
